// File: rtl/oct_display_ctrl_if.sv
// oct_display_ctrl_if: step requests, converter segments and display outputs of the octal display sequencer
interface oct_display_ctrl_if;
  logic        step_up;
  logic        step_dn;
  logic [6:0]  seg_lo_in;
  logic [6:0]  seg_hi_in;
  logic [15:0] code;
  logic [3:0]  idx;
  logic [6:0]  seg;
  logic [1:0]  dig_en;
  logic        frame_tick;
  logic        err;
  modport master (
    output step_up, step_dn, seg_lo_in, seg_hi_in,
    input  code, idx, seg, dig_en, frame_tick, err
  );
  modport slave (
    input  step_up, step_dn, seg_lo_in, seg_hi_in,
    output code, idx, seg, dig_en, frame_tick, err
  );
endinterface

// File: rtl/oct_display_ctrl.sv
// oct_display_ctrl: index stepper and two-digit scan multiplexer for the octal seven-segment converter; define OCT_LZ_SKIP_EN to skip a blank high digit
module oct_display_ctrl #(
  parameter int DWELL     = 1000,
  parameter int GAP       = 4,
  parameter int CNT_W     = 16,
  parameter int START_IDX = 0
) (
  input  logic clk,
  input  logic rst,
  oct_display_ctrl_if.slave bus
);
  typedef enum logic [1:0] {SHOW_LO, BLANK_LO, SHOW_HI, BLANK_HI} state_t;
  localparam logic [CNT_W-1:0] DW_T = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GP_T = CNT_W'(GAP > 0 ? GAP - 1 : 0);
  localparam logic [3:0] IDX0 = 4'(START_IDX);
  state_t state, state_nx;
  logic [CNT_W-1:0] timer;
  logic [3:0] idx_q, idx_nx;
  logic [15:0] code_q;
  logic [6:0] lat_lo, lat_hi, seg_q, seg_nx;
  logic [1:0] dig_q, dig_nx;
  logic lat_valid, entered, last, skip_hi, tick_q, err_q;
  assign idx_nx = bus.step_up == bus.step_dn ? idx_q : bus.step_up ? idx_q + 4'd1 : idx_q - 4'd1;
  assign last = timer == ((state == SHOW_LO || state == SHOW_HI) ? DW_T : GP_T);
`ifdef OCT_LZ_SKIP_EN
  assign skip_hi = lat_hi == 7'd0;
`else
  assign skip_hi = 1'b0;
`endif
  // index, one-hot code and converter latches
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= IDX0;
      code_q    <= 16'd1 << IDX0;
      lat_lo    <= '0;
      lat_hi    <= '0;
      lat_valid <= 1'b0;
    end else begin
      idx_q     <= idx_nx;
      code_q    <= 16'd1 << idx_nx;
      lat_lo    <= bus.seg_lo_in;
      lat_hi    <= bus.seg_hi_in;
      lat_valid <= 1'b1;
    end
  end
  // scan state and phase timer; entered marks a fresh arrival in SHOW_LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SHOW_LO;
      timer   <= '0;
      entered <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= last ? '0 : timer + 1'b1;
      entered <= last && state_nx == SHOW_LO;
    end
  end
  // next scan phase on terminal count; blank phases vanish when GAP is zero
  always_comb begin
    state_nx = state;
    if (last)
      case (state)
        SHOW_LO:  state_nx = GAP == 0 ? (skip_hi ? SHOW_LO : SHOW_HI) : BLANK_LO;
        BLANK_LO: state_nx = skip_hi ? SHOW_LO : SHOW_HI;
        SHOW_HI:  state_nx = GAP == 0 ? SHOW_LO : BLANK_HI;
        default:  state_nx = SHOW_LO;
      endcase
  end
  // segment bus and digit enable selected by the current phase
  always_comb begin
    seg_nx = state == SHOW_LO ? lat_lo : state == SHOW_HI ? lat_hi : 7'd0;
    dig_nx = state == SHOW_LO ? 2'b01 : state == SHOW_HI ? 2'b10 : 2'b00;
  end
  // registered display outputs and sticky converter error
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= '0;
      dig_q  <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      seg_q  <= seg_nx;
      dig_q  <= dig_nx;
      tick_q <= entered;
      err_q  <= err_q | (lat_valid && lat_lo == 7'd0);
    end
  end
  assign bus.idx        = idx_q;
  assign bus.code       = code_q;
  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_q;
  assign bus.frame_tick = tick_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_oct_display_ctrl.sv
// tb_oct_display_ctrl: directed and random stimulus against a frame-position reference model
module tb_oct_display_ctrl;
  localparam int DWELL = 4, GAP = 1, HALF = DWELL + GAP;
  logic clk = 0, rst = 1;
  bit ovr = 0, up = 0, dn = 0;
  int n_checks = 0, n_fail = 0;
  int m_idx = 0, m_pos = 0;
  logic [6:0] m_lo = 0, m_hi = 0, m_seg = 0;
  logic [1:0] m_dig = 0;
  bit m_valid = 0, m_err = 0, m_enter = 0, m_ft = 0;
  logic [13:0] cv;
  int c01, c10, c00, cft, cdir;
  oct_display_ctrl_if bus();
  oct_display_ctrl #(.DWELL(DWELL), .GAP(GAP), .CNT_W(8), .START_IDX(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      default: return 7'b1110000;
    endcase
  endfunction
  function automatic logic [13:0] conv(input logic [15:0] c);
    conv = '0;
    for (int i = 0; i < 16; i++) if (c == 16'd1 << i) conv = {i >= 8 ? seg7(1) : 7'd0, seg7(i % 8)};
  endfunction
  assign cv = conv(bus.code);
  assign bus.seg_lo_in = ovr ? 7'd0 : cv[6:0];
  assign bus.seg_hi_in = cv[13:7];
  task automatic model_step();
    bit show_lo, show_hi, skip;
    int np;
    if (rst) begin
      m_idx = 0; m_lo = 0; m_hi = 0; m_valid = 0; m_err = 0;
      m_pos = 0; m_enter = 0; m_seg = 0; m_dig = 0; m_ft = 0;
      return;
    end
    show_lo = m_pos < DWELL;
    show_hi = m_pos >= HALF && m_pos < HALF + DWELL;
    m_seg = show_lo ? m_lo : show_hi ? m_hi : 7'd0;
    m_dig = {show_hi, show_lo};
    m_ft = m_enter;
    m_err = m_err | (m_valid && m_lo == 7'd0);
`ifdef OCT_LZ_SKIP_EN
    skip = m_hi == 7'd0;
`else
    skip = 0;
`endif
    np = (m_pos == 2 * HALF - 1 || (m_pos == HALF - 1 && skip)) ? 0 : m_pos + 1;
    m_enter = np == 0;
    m_pos = np;
    m_lo = ovr ? 7'd0 : seg7(m_idx % 8);
    m_hi = m_idx >= 8 ? seg7(1) : 7'd0;
    m_valid = 1;
    if (up != dn) m_idx = (m_idx + (up ? 1 : 15)) % 16;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("idx", 16'(bus.idx), 16'(m_idx));
    chk("code", bus.code, 16'd1 << m_idx);
    chk("seg", 16'(bus.seg), 16'(m_seg));
    chk("dig_en", 16'(bus.dig_en), 16'(m_dig));
    chk("frame_tick", 16'(bus.frame_tick), 16'(m_ft));
    chk("err", 16'(bus.err), 16'(m_err));
  endtask
  task automatic cyc(input bit u, input bit d);
    up = u; dn = d; bus.step_up = u; bus.step_dn = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_all();
    up = 0; dn = 0; bus.step_up = 0; bus.step_dn = 0;
  endtask
  task automatic goto_idx(input int t);
    for (int i = 0; i < 16 && m_idx != t; i++) begin cyc(1, 0); cyc(0, 0); end
    chk("goto", 16'(bus.idx), 16'(t));
  endtask
  task automatic window(input int n);
    logic [1:0] prev;
    c01 = 0; c10 = 0; c00 = 0; cft = 0; cdir = 0;
    prev = bus.dig_en;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0);
      c01 += int'(bus.dig_en == 2'b01);
      c10 += int'(bus.dig_en == 2'b10);
      c00 += int'(bus.dig_en == 2'b00);
      cft += int'(bus.frame_tick);
      cdir += int'(prev == 2'b01 && bus.dig_en == 2'b10);
      prev = bus.dig_en;
    end
  endtask
  initial begin
    bus.step_up = 0; bus.step_dn = 0;
    rst = 1;
    repeat (3) cyc(0, 0);
    chk("rst_code", bus.code, 16'h0001);
    chk("rst_idx", 16'(bus.idx), 16'd0);
    chk("rst_seg", 16'(bus.seg), 16'd0);
    chk("rst_dig", 16'(bus.dig_en), 16'd0);
    chk("rst_err", 16'(bus.err), 16'd0);
    rst = 0;
    cyc(0, 0);
    cyc(0, 0);
    chk("first_seg", 16'(bus.seg), 16'(7'b1111110));
    chk("first_dig", 16'(bus.dig_en), 16'(2'b01));
    goto_idx(9);
    chk("code9", bus.code, 16'h0200);
    repeat (4) cyc(0, 0);
    window(20);
    chk("scan_lo", 16'(c01), 16'd8);
    chk("scan_hi", 16'(c10), 16'd8);
    chk("scan_blank", 16'(c00), 16'd4);
    chk("scan_tick", 16'(cft), 16'd2);
    chk("scan_direct", 16'(cdir), 16'd0);
    goto_idx(15);
    cyc(1, 0);
    chk("wrap_up_idx", 16'(bus.idx), 16'd0);
    chk("wrap_up_code", bus.code, 16'h0001);
    cyc(0, 1);
    chk("wrap_dn_idx", 16'(bus.idx), 16'd15);
    chk("wrap_dn_code", bus.code, 16'h8000);
    cyc(1, 1);
    chk("both_idx", 16'(bus.idx), 16'd15);
    goto_idx(3);
    for (int i = 0; i < 20 && m_pos != 1; i++) cyc(0, 0);
    chk("lat_phase", 16'(m_pos), 16'd1);
    cyc(1, 0);
    chk("lat_code", bus.code, 16'h0010);
    cyc(0, 0);
    cyc(0, 0);
    chk("lat_seg", 16'(bus.seg), 16'(7'b0110011));
    repeat (300) begin
      int r;
      r = $urandom_range(0, 7);
      cyc(r == 0 || r == 2, r == 1 || r == 2);
    end
    rst = 1;
    cyc(1, 0);
    chk("rst_step_idx", 16'(bus.idx), 16'd0);
    rst = 0;
    repeat (3) cyc(0, 0);
    rst = 1;
    cyc(0, 0);
    rst = 0;
    ovr = 1;
    cyc(0, 0);
    ovr = 0;
    cyc(0, 0);
    chk("err_set", 16'(bus.err), 16'd1);
    repeat (5) cyc(0, 0);
    chk("err_sticky", 16'(bus.err), 16'd1);
    rst = 1;
    cyc(0, 0);
    chk("err_clr", 16'(bus.err), 16'd0);
    rst = 0;
`ifdef OCT_LZ_SKIP_EN
    goto_idx(5);
    repeat (12) cyc(0, 0);
    window(20);
    chk("lz_no_hi", 16'(c10), 16'd0);
    chk("lz_tick", 16'(cft), 16'd4);
    goto_idx(8);
    window(2 * HALF + 2);
    chk("lz_restore", 16'(c10 > 0), 16'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/oct_display_ctrl.md
Name: oct_display_ctrl

Overview:
- Sequencer for the one-hot-to-octal seven-segment converter.
- Holds the current value index (0..15) and drives the converter's 16-bit one-hot input; steps up or down on pulse requests with wrap-around.
- Registers the converter's two segment outputs.
- Time-multiplexes the two digits onto one shared segment bus, with per-digit enables and a blanking gap between digits.

Parameters:
- DWELL, 1000: cycles each digit is shown per scan; must be >=1.
- GAP, 4: blank cycles after each digit; 0 means no blank phase.
- CNT_W, 16: phase timer width; must hold max(DWELL,GAP)-1.
- START_IDX, 0: index loaded on reset, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- step_up  in  1  single-cycle pulse: index +1.
- step_dn  in  1  single-cycle pulse: index -1.
- seg_lo_in  in  7  converter low-digit segments {a..g}.
- seg_hi_in  in  7  converter high-digit segments {a..g}.
- code  out  16  one-hot value to converter; bit idx set.
- idx  out  4  current index.
- seg  out  7  shared segment bus, active-high.
- dig_en  out  2  digit enables, active-high; bit0 = low digit, bit1 = high digit; at most one bit set.
- frame_tick  out  1  one-cycle pulse on each entry to SHOW_LO, except the reset entry.
- err  out  1  sticky: converter returned blank low digit.

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: idx=START_IDX, code=1<<START_IDX, seg=0, dig_en=00, frame_tick=0, err=0, state=SHOW_LO, timer=0, lat_lo=lat_hi=0, lat_valid=0.
- Reset asserted mid-scan or mid-step returns everything to the reset values on the next edge; a step pulse in the same cycle as rst is ignored.

Index control:
- step_up only: idx=idx+1 mod 16 (15->0).
- step_dn only: idx=idx-1 mod 16 (0->15).
- Both, or neither: idx holds.
- code always equals 1<<idx and is updated on the same edge as idx.

Latching:
- lat_lo and lat_hi capture seg_lo_in and seg_hi_in every cycle.
- lat_valid goes to 1 on the first edge after reset release.

Latency:
- Step pulse sampled at edge k: code valid after k, latches updated at k+1, seg reflects the new value at k+2 if the FSM is in the matching SHOW phase.

Scan FSM (states SHOW_LO, BLANK_LO, SHOW_HI, BLANK_HI, in that order, cyclic):
- Timer counts 0..DWELL-1 in SHOW states and 0..GAP-1 in BLANK states.
- On terminal count, advance to the next state and clear the timer.
- GAP=0: BLANK states are skipped, SHOW_LO->SHOW_HI->SHOW_LO.
- Scan period is 2*(DWELL+GAP) cycles.

Outputs registered from the current state:
- SHOW_LO: seg=lat_lo, dig_en=01.
- SHOW_HI: seg=lat_hi, dig_en=10.
- BLANK_LO / BLANK_HI: seg=0, dig_en=00.
- dig_en never changes directly from 01 to 10 when GAP>=1.
- frame_tick=1 in the cycle the output first reflects SHOW_LO after a wrap from BLANK_HI (or from SHOW_HI when GAP=0).

Error:
- err is set when lat_valid=1 and lat_lo==0, i.e. the converter saw a non-one-hot input.
- err is cleared only by rst.

Optional Feature:
- Macro: OCT_LZ_SKIP_EN.
- Defined: on leaving BLANK_LO (or SHOW_LO when GAP=0), if lat_hi==0 the FSM returns to SHOW_LO and skips SHOW_HI/BLANK_HI. The scan period becomes DWELL+GAP and frame_tick fires on each return. The decision is re-evaluated each pass, so a step from 7 to 8 restores the high-digit phases on the next pass.
- Not defined: the high-digit phases always run; with lat_hi==0 they output seg=0 with dig_en=10.

Test Plan:
- Reset hold: DWELL=4, GAP=1, START_IDX=0, rst for 3 cycles -> code=0x0001, idx=0, seg=0, dig_en=00, err=0; 2 cycles after release seg=7'b1111110 with dig_en=01.
- Scan timing: idx=9 (code=0x0200), converter returns lo=7'b0110000, hi=7'b0110000 -> pattern 4 cycles dig_en=01, 1 cycle 00, 4 cycles 10, 1 cycle 00; frame_tick every 10 cycles.
- Wrap: idx=15, pulse step_up -> idx=0, code=0x0001; then pulse step_dn -> idx=15, code=0x8000; step_up and step_dn together -> idx unchanged.
- Latency: at idx=3 in mid SHOW_LO, pulse step_up at edge k -> code=0x0010 after k, seg=7'b0110011 from k+2.
- Error: force seg_lo_in=0 for 1 cycle after reset release -> err=1 next cycle and stays 1 until rst.
- OCT_LZ_SKIP_EN: idx=5 (hi=0) -> dig_en never 10, period 5 cycles; step to idx=8 -> high-digit phases reappear within one pass.
